param_regfile: RTL
==================

PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 SHALL take parameter WIDTH, default 32, meaning data bits per register; it must be a multiple of 8.
REQ-002 SHALL take parameter DEPTH, default 32, meaning register count; it must be a power of 2 and at least 4.
REQ-003 SHALL take parameter ZERO_REG, default 1; when 1, register 0 always reads 0 and writes to it are discarded.
REQ-004 SHALL take parameter BYPASS, default 0; when 1, a read of the address being written this cycle returns the post-write value.
REQ-005 SHALL define localparam AW = log2(DEPTH) and localparam NB = WIDTH/8.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port wr_en, input, 1 bit: write request.
REQ-009 SHALL have port wr_addr, input, AW bits: write address.
REQ-010 SHALL have port wr_data, input, WIDTH bits: write data.
REQ-011 SHALL have port wr_be, input, NB bits: byte enables; bit i covers wr_data[8i+7:8i].
REQ-012 SHALL have ports rd_addr_a and rd_addr_b, inputs, AW bits each: read addresses.
REQ-013 SHALL have ports rd_data_a and rd_data_b, outputs, WIDTH bits each: read data.
REQ-014 SHALL have port clr_req, input, 1 bit: one-cycle pulse requesting a full-array clear.
REQ-015 SHALL have port busy, output, 1 bit: high while a clear sweep is in progress.

Function
REQ-016 SHALL use a two-state FSM with states CLEAR and IDLE.
REQ-017 SHALL keep a sweep pointer ptr of AW bits.
REQ-018 In CLEAR, SHALL write all-zero to entry ptr on each cycle, then increment ptr.
REQ-019 In CLEAR, when ptr == DEPTH-1, SHALL write that entry, move to IDLE and wrap ptr to 0, so a sweep lasts exactly DEPTH cycles.
REQ-020 In IDLE, a cycle with clr_req=1 SHALL move the FSM to CLEAR on the next edge with ptr=0.
REQ-021 A clr_req received while already in CLEAR SHALL be ignored; the sweep does not restart.
REQ-022 busy SHALL be 1 exactly when the state is CLEAR (registered; no combinational path from clr_req).
REQ-023 A write SHALL occur in IDLE when wr_en=1; only bytes with wr_be=1 are updated and the other bytes are kept.
REQ-024 wr_en while busy=1 SHALL be dropped, with no queuing.
REQ-025 A write in the same IDLE cycle as clr_req SHALL complete; the sweep then clears that entry.
REQ-026 Read ports SHALL be combinational from address to data, with zero latency.
REQ-027 While busy=1, both read ports SHALL return 0 regardless of the array contents.
REQ-028 With ZERO_REG=1, reading address 0 SHALL return 0 and no write to address 0 has any effect.
REQ-029 With BYPASS=0, a read of the address being written SHALL return the old value until the edge.
REQ-030 With BYPASS=1, a read of the address being written SHALL return the old value merged with the enabled wr_data bytes; the bypass does not apply to address 0 when ZERO_REG=1, and does not apply while busy.
REQ-031 Both ports reading the same address SHALL return identical data.

Reset
REQ-032 While rst_n=0, the state SHALL be CLEAR, ptr SHALL be 0 and busy SHALL be 1, taking effect asynchronously.
REQ-033 rd_data_a and rd_data_b SHALL read 0 during reset.
REQ-034 The array itself SHALL NOT be reset; it is zeroed by the post-reset sweep, which starts on the first edge after rst_n rises.
REQ-035 Reset asserted mid-sweep or mid-operation SHALL abort the activity, and a full sweep SHALL restart from ptr=0.

Structure
REQ-036 The FSM state encoding and a clog2-style function SHALL live in the shared package regfile_pkg.
REQ-037 The byte-enable merge SHALL be one sub-module, be_merge (old, new, be -> merged), used by both the write path and the bypass path.
REQ-038 The array SHALL be a plain storage array with no per-entry reset.

Verification
REQ-039 Release reset with DEPTH=32: busy=1 for exactly 32 cycles, then 0; reads of every address return 0.
REQ-040 Write 0xDEADBEEF to reg 5 with be=0xF, then 0x00000011 with be=0x1: reg 5 reads 0xDEADBE11 on both ports.
REQ-041 Write 12 to reg 0 with ZERO_REG=1: both ports read 0. Write reg 3 with wr_en=1 while busy: the write is lost after the sweep.
REQ-042 With BYPASS=1, write 0x55 to reg 7 with rd_addr_a=7 in the same cycle: rd_data_a=0x55 before the edge. With BYPASS=0: the old value is read.
REQ-043 Pulse clr_req after filling regs 1..31 with 0xA5A5A5A5: busy for 32 cycles, then all reads return 0. A second clr_req mid-sweep does not extend busy.
REQ-044 Drop rst_n during sweep cycle 10: busy stays 1, and the sweep then takes a full 32 cycles from ptr=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file: FSM states and a
// ceiling-log2 helper used to size address ports.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/param_regfile_be_merge.sv
// Byte-enable merge: each byte of the result comes from new_data when its
// enable bit is set, otherwise from old_data.
module be_merge #(
  parameter  int WIDTH = 32,
  localparam int NB    = WIDTH / 8
) (
  input  logic [WIDTH-1:0] old_data,
  input  logic [WIDTH-1:0] new_data,
  input  logic [NB-1:0]    be,
  output logic [WIDTH-1:0] merged
);

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign merged[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
  end

endmodule

// File: rtl/param_regfile.sv
// Two-read, one-write register file with byte enables, optional hard-wired
// zero register, optional write-to-read bypass and a full-array clear sweep.
module param_regfile
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 0,
  localparam int AW       = clog2(DEPTH),
  localparam int NB       = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [NB-1:0]    wr_be,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             clr_req,
  output logic             busy
);

  state_t           state;
  state_t           next_state;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    next_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr_merged;
  logic             wr_to_zero;
  logic             do_write;
  logic             hit_a;
  logic             hit_b;

  // Reset parks the FSM in CLEAR so the array is swept once reset lifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    case (state)
      CLEAR: begin
        next_ptr = ptr + 1'b1;
        if (ptr == AW'(DEPTH - 1)) begin
          next_state = IDLE;
        end
      end
      IDLE: begin
        if (clr_req) begin
          next_state = CLEAR;
          next_ptr   = '0;
        end
      end
      default: begin
        next_state = CLEAR;
        next_ptr   = '0;
      end
    endcase
  end

  assign busy = (state == CLEAR);

  // One merge unit serves both the array write and the bypass read path.
  be_merge #(
    .WIDTH (WIDTH)
  ) u_merge (
    .old_data (mem[wr_addr]),
    .new_data (wr_data),
    .be       (wr_be),
    .merged   (wr_merged)
  );

  assign wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign do_write   = (state == IDLE) && wr_en && !wr_to_zero;

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (do_write) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  assign hit_a = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_a);
  assign hit_b = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_b);

  // Busy masking has priority, then the zero register, then the bypass.
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    if (busy || ((ZERO_REG != 0) && (rd_addr_a == '0))) begin
      rd_data_a = '0;
    end else if (hit_a) begin
      rd_data_a = wr_merged;
    end
  end

  always_comb begin
    rd_data_b = mem[rd_addr_b];
    if (busy || ((ZERO_REG != 0) && (rd_addr_b == '0))) begin
      rd_data_b = '0;
    end else if (hit_b) begin
      rd_data_b = wr_merged;
    end
  end

endmodule
